// File: rtl/bist_response_analyzer_pkg.sv
// rtl/bist_response_analyzer_pkg.sv - shared FSM encoding, MISR defaults and MISR step function
package bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int          MISR_MAX_W = 64;
   localparam logic [15:0] DEF_POLY   = 16'h1021;
   localparam logic [15:0] DEF_SEED   = 16'hFFFF;

   // Galois left-shift step; callers pass zero-extended operands and truncate the result.
   function automatic logic [MISR_MAX_W-1:0] misr_next(
      input logic [MISR_MAX_W-1:0] cur,
      input logic [MISR_MAX_W-1:0] poly,
      input logic [MISR_MAX_W-1:0] data,
      input logic [5:0]            msb_idx
   );
      return ((cur << 1) ^ (cur[msb_idx] ? poly : '0)) ^ data;
   endfunction

endpackage

// File: rtl/bist_response_analyzer_if.sv
// rtl/bist_response_analyzer_if.sv - compacted response stream into the analyzer
// Macro BIST_XMASK_EN adds the per-bit X mask alongside resp.
interface bist_response_analyzer_if #(parameter int W = 6);

   logic [W-1:0] resp;
   logic         resp_valid;
   logic         resp_ready;
`ifdef BIST_XMASK_EN
   logic [W-1:0] resp_xmask;

   modport master (output resp, resp_valid, resp_xmask, input resp_ready);
   modport slave  (input resp, resp_valid, resp_xmask, output resp_ready);
`else
   modport master (output resp, resp_valid, input resp_ready);
   modport slave  (input resp, resp_valid, output resp_ready);
`endif

endinterface

// File: rtl/bist_response_analyzer_misr.sv
// rtl/bist_response_analyzer_misr.sv - multiple-input signature register, seeded on load
module misr_reg
   import bist_pkg::*;
#(
   parameter int               W     = 6,
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
   parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             enable_i,
   input  logic [W-1:0]     data_i,
   output logic [SIG_W-1:0] state_o
);

   logic [SIG_W-1:0] misr_q;
   logic [SIG_W-1:0] misr_d;

   assign misr_d = SIG_W'(misr_next(MISR_MAX_W'(misr_q), MISR_MAX_W'(POLY),
                                    MISR_MAX_W'(data_i), 6'(SIG_W - 1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         misr_q <= '0;
      end else if (load_i) begin
         misr_q <= SEED;
      end else if (enable_i) begin
         misr_q <= misr_d;
      end
   end

   assign state_o = misr_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - folds compacted responses into a MISR and checks the golden signature
// Macro BIST_XMASK_EN masks X bits of each response out of the signature.
module bist_response_analyzer
   import bist_pkg::*;
#(
   parameter int               W     = 6,
   parameter int               SIG_W = 16,
   parameter int               CNT_W = 16,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
   parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic [CNT_W-1:0]          pattern_count,
   input  logic [SIG_W-1:0]          golden_sig,
   bist_response_analyzer_if.slave   rsp_if,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [SIG_W-1:0]          signature
);

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] RUN   = ST_RUN;
   localparam logic [1:0] CHECK = ST_CHECK;
   localparam logic [1:0] DONE  = ST_DONE;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             pass_q, pass_d;
   logic [SIG_W-1:0] sig_q, sig_d;
   logic [SIG_W-1:0] misr;
   logic [W-1:0]     resp_eff;
   logic             load;
   logic             accept;

`ifdef BIST_XMASK_EN
   assign resp_eff = rsp_if.resp & ~rsp_if.resp_xmask;
`else
   assign resp_eff = rsp_if.resp;
`endif

   // abort wins over a simultaneous beat, so the beat never reaches the MISR
   assign load   = (state_q == IDLE) && start;
   assign accept = (state_q == RUN) && rsp_if.resp_valid && !abort;

   misr_reg #(
      .W     (W),
      .SIG_W (SIG_W),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load),
      .enable_i (accept),
      .data_i   (resp_eff),
      .state_o  (misr)
   );

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      pass_d      = pass_q;
      sig_d       = sig_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               remaining_d = pattern_count;
               pass_d      = 1'b0;
               state_d     = (pattern_count != '0) ? RUN : CHECK;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (accept) begin
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == CNT_W'(1)) state_d = CHECK;
            end
         end
         CHECK: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               sig_d   = misr;
               pass_d  = (misr == golden_sig);
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         pass_q      <= 1'b0;
         sig_q       <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         pass_q      <= pass_d;
         sig_q       <= sig_d;
      end
   end

   assign rsp_if.resp_ready = (state_q == RUN);
   assign busy              = (state_q == RUN) || (state_q == CHECK);
   assign done              = (state_q == DONE);
   assign pass              = pass_q;
   assign signature         = sig_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - directed self-checking bench for bist_response_analyzer
module tb_bist_response_analyzer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] pattern_count;
   logic [15:0] golden_sig;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] signature;

   bist_response_analyzer_if #(.W(6)) rif ();

   bist_response_analyzer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .pattern_count (pattern_count),
      .golden_sig    (golden_sig),
      .rsp_if        (rif),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .signature     (signature)
   );

   int errors = 0;
   int checks = 0;

   bit          chk_en = 0;
   bit          e_ready, e_busy, e_done, e_pass;
   logic [15:0] e_sig;
   logic [5:0]  xm = 6'h00;
   logic [5:0]  q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Signature from the arithmetic definition: multiply by two mod 2^16, fold the
   // polynomial when the dropped bit was set, then xor in the (masked) response.
   function automatic logic [15:0] sig_of(input logic [5:0] rs[$], input int n, input logic [5:0] mask);
      int m = 'hFFFF;
      int r;
      for (int i = 0; i < n; i++) begin
`ifdef BIST_XMASK_EN
         r = int'(rs[i] & ~mask);
`else
         r = int'(rs[i]);
`endif
         m = ((m * 2) % 65536) ^ ((m >= 32768) ? 'h1021 : 0) ^ r;
      end
      return 16'(m);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("resp_ready", 16'(rif.resp_ready), 16'(e_ready));
         chk("busy",       16'(busy),           16'(e_busy));
         chk("done",       16'(done),           16'(e_done));
         chk("pass",       16'(pass),           16'(e_pass));
         chk("signature",  signature,           e_sig);
      end
   end

   task automatic cyc(input bit r, input bit b, input bit d);
      e_ready = r;
      e_busy  = b;
      e_done  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int pc, input logic [5:0] rs[$], input logic [15:0] gold,
                      input bit gap, input bit poke_start);
      int  i = 0;
      int  t = 0;
      bit  v;
      start         = 1'b1;
      pattern_count = 16'(pc);
      golden_sig    = gold;
      cyc(0, 0, 0);
      start  = 1'b0;
      e_pass = 1'b0;
      while (i < pc) begin
         v              = !(gap && t[0]);
         rif.resp_valid = v;
         rif.resp       = v ? rs[i] : 6'h2A;
         start          = poke_start && (t == 1);
         cyc(1, 1, 0);
         if (v) i++;
         t++;
      end
      rif.resp_valid = 1'b0;
      start          = 1'b0;
      cyc(0, 1, 0);
      e_sig  = sig_of(rs, pc, xm);
      e_pass = (e_sig == gold);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
   endtask

   initial begin
      rst            = 1'b1;
      start          = 1'b0;
      abort          = 1'b0;
      pattern_count  = '0;
      golden_sig     = '0;
      rif.resp       = '0;
      rif.resp_valid = 1'b0;
`ifdef BIST_XMASK_EN
      rif.resp_xmask = '0;
`endif
      @(posedge clk);
      #1;
      e_pass = 1'b0;
      e_sig  = 16'h0000;
      chk_en = 1'b1;
      cyc(0, 0, 0);
      rst = 1'b0;
      cyc(0, 0, 0);

      q = {6'h00};
      chk("model_pin1", sig_of(q, 1, 6'h00), 16'hEFDF);
      q = {6'h3F, 6'h00};
      chk("model_pin2", sig_of(q, 2, 6'h00), 16'hCFE1);

      q = {6'h00};
      run(1, q, 16'hEFDF, 0, 0);
      chk("t1_sig", signature, 16'hEFDF);
      chk("t1_pass", 16'(pass), 16'd1);

      q = {6'h3F, 6'h00};
      run(2, q, 16'hCFE1, 0, 0);
      chk("t2_sig", signature, 16'hCFE1);
      run(2, q, 16'h0000, 0, 0);
      chk("t2b_pass", 16'(pass), 16'd0);
      chk("t2b_sig", signature, 16'hCFE1);

      // abort after two accepts, with a beat offered in the abort cycle
      start = 1'b1; pattern_count = 16'd4; golden_sig = 16'h1234;
      cyc(0, 0, 0);
      start = 1'b0;
      rif.resp_valid = 1'b1;
      rif.resp = 6'h11; cyc(1, 1, 0);
      rif.resp = 6'h22; cyc(1, 1, 0);
      abort = 1'b1; rif.resp = 6'h33; cyc(1, 1, 0);
      abort = 1'b0;
      for (int k = 0; k < 3; k++) cyc(0, 0, 0);
      rif.resp_valid = 1'b0;
      chk("abort_sig", signature, 16'hCFE1);

      // abort landing in CHECK
      start = 1'b1; pattern_count = 16'd1; golden_sig = 16'hEFDF;
      cyc(0, 0, 0);
      start = 1'b0; rif.resp_valid = 1'b1; rif.resp = 6'h00;
      cyc(1, 1, 0);
      rif.resp_valid = 1'b0; abort = 1'b1;
      cyc(0, 1, 0);
      abort = 1'b0;
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      q = {};
      run(0, q, 16'hFFFF, 0, 0);
      chk("t3_sig", signature, 16'hFFFF);
      chk("t3_pass", 16'(pass), 16'd1);

      q = {6'h01, 6'h22, 6'h3C};
      run(3, q, 16'h8F63, 0, 0);
      chk("t4_sig", signature, 16'h8F63);
      run(3, q, 16'h8F63, 1, 1);
      chk("t4_gap_sig", signature, 16'h8F63);
      chk("t4_gap_pass", 16'(pass), 16'd1);

      // maximum count: still running after a few accepts, no wrap on load
      start = 1'b1; pattern_count = 16'hFFFF;
      cyc(0, 0, 0);
      start = 1'b0; e_pass = 1'b0;
      rif.resp_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rif.resp = 6'(k);
         cyc(1, 1, 0);
      end
      rif.resp_valid = 1'b0;
      cyc(1, 1, 0);
      abort = 1'b1; cyc(1, 1, 0);
      abort = 1'b0; cyc(0, 0, 0);

      // reset mid-run clears result registers
      start = 1'b1; pattern_count = 16'd3;
      cyc(0, 0, 0);
      start = 1'b0; rif.resp_valid = 1'b1; rif.resp = 6'h05;
      cyc(1, 1, 0);
      rst = 1'b1;
      cyc(1, 1, 0);
      rst = 1'b0; rif.resp_valid = 1'b0;
      e_pass = 1'b0; e_sig = 16'h0000;
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      q = {6'h00};
      run(1, q, 16'hEFDF, 0, 0);
      chk("post_rst_sig", signature, 16'hEFDF);

`ifdef BIST_XMASK_EN
      xm = 6'h3F;
      rif.resp_xmask = xm;
      q = {6'h3F};
      run(1, q, 16'hEFDF, 0, 0);
      chk("xmask_sig", signature, 16'hEFDF);
      xm = 6'h00;
      rif.resp_xmask = xm;
`endif

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
